// File: rtl/adc_pipe.sv
// adc_pipe: pipelined add/subtract-with-carry, one CHUNK-bit carry stage per register stage
//
// Parameters:
//   WIDTH      operand/result width, must be a multiple of CHUNK
//   CHUNK      bits resolved per stage; latency STAGES = WIDTH/CHUNK cycles
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand beat valid        in_ready   beat accepted this cycle
//   a, b       operands                  C0         carry in
//   sub        1: a + ~b + C0, 0: a + b + C0
//   out_valid  result valid              out_ready  downstream accepts result
//   s          sum/difference            Co         carry out of bit WIDTH-1
//   ovf        signed overflow
// Build option:
//   ADC_PIPE_SAT_EN adds input sat; a sat beat that overflows returns the saturated value.
module adc_pipe #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             C0,
  input  logic             sub,
`ifdef ADC_PIPE_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             Co,
  output logic             ovf
);
  localparam int STAGES = WIDTH / CHUNK;
  localparam int L = STAGES - 1;

  if (WIDTH % CHUNK != 0 || CHUNK > WIDTH) begin : g_bad_cfg
    $error("adc_pipe: WIDTH must be a positive multiple of CHUNK");
  end

  // Per-stage registers. Operands travel whole so the final stage still sees the MSBs
  // for overflow; b is stored already conditionally inverted.
  logic [WIDTH-1:0] a_r [STAGES];
  logic [WIDTH-1:0] b_r [STAGES];
  logic [WIDTH-1:0] s_r [STAGES];
  logic             c_r [STAGES];
  logic             v_r [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_d [STAGES];
  logic             adv;

  // Whole pipe moves together; it only freezes when the output beat is blocked.
  assign adv = !v_r[L] || out_ready;
  assign in_ready = adv;

  always_comb begin
    logic [WIDTH-1:0] pa, pb, ps;
    logic             pc;
    logic [CHUNK:0]   sm;
    for (int k = 0; k < STAGES; k++) begin
      pa = (k == 0) ? a : a_r[(k == 0) ? 0 : k - 1];
      pb = (k == 0) ? (sub ? ~b : b) : b_r[(k == 0) ? 0 : k - 1];
      ps = (k == 0) ? '0 : s_r[(k == 0) ? 0 : k - 1];
      pc = (k == 0) ? C0 : c_r[(k == 0) ? 0 : k - 1];
      sm = {1'b0, pa[k*CHUNK +: CHUNK]} + {1'b0, pb[k*CHUNK +: CHUNK]} + (CHUNK+1)'(pc);
      s_d[k] = ps;
      s_d[k][k*CHUNK +: CHUNK] = sm[CHUNK-1:0];
      c_d[k] = sm[CHUNK];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= '0;
        b_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
        v_r[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_r[k] <= (k == 0) ? a : a_r[(k == 0) ? 0 : k - 1];
        b_r[k] <= (k == 0) ? (sub ? ~b : b) : b_r[(k == 0) ? 0 : k - 1];
        v_r[k] <= (k == 0) ? in_valid : v_r[(k == 0) ? 0 : k - 1];
        s_r[k] <= s_d[k];
        c_r[k] <= c_d[k];
      end
    end
  end

  logic a_msb;
  assign a_msb = a_r[L][WIDTH-1];
  assign out_valid = v_r[L];
  assign Co = c_r[L];
  assign ovf = (a_msb == b_r[L][WIDTH-1]) && (s_r[L][WIDTH-1] != a_msb);

`ifdef ADC_PIPE_SAT_EN
  logic sat_r [STAGES];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) sat_r[k] <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) sat_r[k] <= (k == 0) ? sat : sat_r[(k == 0) ? 0 : k - 1];
    end
  end
  // Clamp toward the sign of a: positive overflow -> max, negative -> min.
  assign s = (sat_r[L] && ovf) ? {a_msb, {(WIDTH-1){~a_msb}}} : s_r[L];
`else
  assign s = s_r[L];
`endif
endmodule

// File: tb/tb_adc_pipe.sv
// tb_adc_pipe: self-checking bench for adc_pipe (WIDTH=32, CHUNK=8) with table vectors and a scoreboard model
module tb_adc_pipe;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] a = 0, b = 0;
  logic        C0 = 0, sub = 0, sat = 0;
  logic        out_valid, out_ready = 1;
  logic [31:0] s;
  logic        Co, ovf;

  always #5 clk = ~clk;

  adc_pipe #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .C0(C0), .sub(sub),
`ifdef ADC_PIPE_SAT_EN
    .sat(sat),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .Co(Co), .ovf(ovf));

  typedef struct {
    logic [31:0] s;
    logic        co, ovf;
  } res_t;

  typedef struct {
    logic [31:0] a, b;
    logic        c0, sub, sat;
    logic [31:0] es;
    logic        eco, eovf;
  } vec_t;

  int   n_cmp = 0, n_bad = 0, n_rx = 0;
  res_t sb[$];
  res_t e_m;

  // Reference: plain 33-bit arithmetic on the two's-complement operands.
  function automatic res_t model(logic [31:0] x, logic [31:0] y, logic c, logic sb_sub, logic st);
    res_t        r;
    logic [31:0] yy;
    logic [32:0] t;
    yy = sb_sub ? ~y : y;
    t = {1'b0, x} + {1'b0, yy} + 33'(c);
    r.s = t[31:0];
    r.co = t[32];
    r.ovf = (x[31] == yy[31]) && (r.s[31] != x[31]);
`ifdef ADC_PIPE_SAT_EN
    if (st && r.ovf) r.s = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: record accepted beats, compare every delivered result in order.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(model(a, b, C0, sub, sat));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_extra: got result %h expected none", s);
        end else begin
          e_m = sb.pop_front();
          chk("sb_s", s, e_m.s);
          chk("sb_co", 32'(Co), 32'(e_m.co));
          chk("sb_ovf", 32'(ovf), 32'(e_m.ovf));
          n_rx++;
        end
      end
    end
  end

  task automatic drive(logic [31:0] x, logic [31:0] y, logic c, logic sb_sub, logic st);
    a = x; b = y; C0 = c; sub = sb_sub; sat = st;
  endtask

  task automatic send_one(vec_t v, string name);
    int lat;
    @(posedge clk); #1;
    drive(v.a, v.b, v.c0, v.sub, v.sat);
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    for (lat = 1; lat < 20; lat++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
    end
    chk({name, "_lat"}, 32'(lat), 32'd4);
    chk({name, "_s"}, s, v.es);
    chk({name, "_co"}, 32'(Co), 32'(v.eco));
    chk({name, "_ovf"}, 32'(ovf), 32'(v.eovf));
  endtask

  task automatic wait_drain(string name);
    int c;
    out_ready = 1;
    in_valid = 0;
    for (c = 0; c < 50 && sb.size() != 0; c++) @(negedge clk);
    chk({name, "_drained"}, 32'(sb.size()), 32'd0);
  endtask

  vec_t tbl[$];

  initial begin
    logic [31:0] sa[8], sbv[8], held;
    logic        have;
    int          i, cyc, rx0;
    tbl.push_back('{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0});
    tbl.push_back('{32'hAAAAAAAA, 32'h55555556, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
    tbl.push_back('{32'h00000000, 32'h00000001, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0});
    tbl.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1});
    tbl.push_back('{32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1});
    tbl.push_back('{32'h00000000, 32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000001, 1'b0, 1'b0});
    tbl.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0});
    tbl.push_back('{32'h12345678, 32'h00FF00FF, 1'b0, 1'b0, 1'b0, 32'h13335777, 1'b0, 1'b0});
    tbl.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1});
`ifdef ADC_PIPE_SAT_EN
    tbl.push_back('{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1});
    tbl.push_back('{32'h80000000, 32'h00000001, 1'b1, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1});
    tbl.push_back('{32'h12345678, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h12345679, 1'b0, 1'b0});
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_s", s, 32'd0);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_co", 32'(Co), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    foreach (tbl[k]) send_one(tbl[k], $sformatf("vec%0d", k));
    wait_drain("table");

    // 8 back-to-back beats with a 3-cycle output stall in the middle
    for (int k = 0; k < 8; k++) begin
      sa[k] = $urandom;
      sbv[k] = $urandom;
    end
    rx0 = n_rx;
    i = 0;
    cyc = 0;
    have = 0;
    held = 0;
    while (i < 8 && cyc < 100) begin
      @(posedge clk); #1;
      drive(sa[i], sbv[i], i[0], i[1], 1'b0);
      in_valid = 1;
      out_ready = !(cyc >= 5 && cyc < 8);
      @(negedge clk);
      if (!out_ready && out_valid) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (have) chk("stall_hold_s", s, held);
        held = s;
        have = 1;
      end
      if (in_valid && in_ready) i++;
      cyc++;
    end
    @(posedge clk); #1;
    wait_drain("stream");
    chk("stream_count", 32'(n_rx - rx0), 32'd8);
    chk("stream_stalled", 32'(have), 32'd1);

    // Reset with 3 beats in flight, output blocked and showing a nonzero result
    @(posedge clk); #1;
    out_ready = 0;
    drive(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0, 1'b0);
    in_valid = 1;
    repeat (3) @(posedge clk);
    #1 in_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #2;
    rst_n = 0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_s", s, 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    send_one(tbl[0], "post_rst");
    wait_drain("post_rst");

    // Random traffic with random valid/ready
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      drive($urandom_range(0, 3) == 0 ? 32'h7FFFFFFF : $urandom,
            $urandom_range(0, 3) == 0 ? 32'hFFFFFFFF : $urandom,
            1'($urandom), 1'($urandom), 1'($urandom));
      in_valid = $urandom_range(0, 9) < 7;
      out_ready = $urandom_range(0, 3) != 0;
    end
    @(posedge clk); #1;
    wait_drain("random");
    chk("random_rx_nonzero", 32'(n_rx > 100), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
